// File: rtl/nco_pkg.sv
// Shared NCO widths and state encoding, common to nco_core and the main control FSM.
package nco_pkg;

  localparam int NCO_DATA_W  = 8;
  localparam int NCO_ADDR_W  = 8;
  localparam int NCO_FREQ_W  = 14;
  localparam int NCO_PHASE_W = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } nco_state_t;

endpackage

// File: rtl/nco_lut_ram.sv
// Waveform table: one write port, one registered read port; the array itself is never reset.
module nco_lut_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Table write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register clears on reset and holds its value while no read is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/nco_core.sv
// NCO core: loads a waveform table from the control write stream, then plays it back
// through a phase accumulator whose step is only updated at period boundaries.
module nco_core
  import nco_pkg::*;
#(
  parameter int DATA_W  = NCO_DATA_W,
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int FREQ_W  = NCO_FREQ_W,
  parameter int PHASE_W = NCO_PHASE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              nco_we_i,
  input  logic [DATA_W-1:0] nco_data_i,
  input  logic [FREQ_W-1:0] nco_freq_step_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_vld_o,
  output logic              wrap_o,
  output logic              loaded_o,
  output logic              wr_drop_o
);

  nco_state_t         state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [PHASE_W-1:0] phase_q;
  logic [FREQ_W-1:0]  step_q;
  logic [PHASE_W:0]   phase_sum;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_raddr;

  // Extra top bit captures the accumulator carry-out that marks a period boundary.
  assign phase_sum = {1'b0, phase_q} + {{(PHASE_W + 1 - FREQ_W){1'b0}}, step_q};
  assign ram_raddr = phase_q[PHASE_W-1 -: ADDR_W];

  // Table port control: writes only outside S_RUN, reads only in S_RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {ADDR_W{1'b0}};
    ram_re    = 1'b0;
    case (state)
      S_IDLE: begin
        ram_we    = nco_we_i;
        ram_waddr = {ADDR_W{1'b0}};
      end
      S_LOAD: begin
        ram_we    = nco_we_i;
        ram_waddr = wr_ptr;
      end
      S_RUN: begin
        ram_re = 1'b1;
      end
      default: begin
        ram_we = 1'b0;
        ram_re = 1'b0;
      end
    endcase
  end

  nco_lut_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_lut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (nco_data_i),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (sample_o)
  );

  // Control FSM, phase accumulator and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wr_ptr       <= {ADDR_W{1'b0}};
      phase_q      <= {PHASE_W{1'b0}};
      step_q       <= {FREQ_W{1'b0}};
      sample_vld_o <= 1'b0;
      wrap_o       <= 1'b0;
      loaded_o     <= 1'b0;
      wr_drop_o    <= 1'b0;
    end else begin
      sample_vld_o <= (state == S_RUN);
      case (state)
        S_IDLE: begin
          wrap_o <= 1'b0;
          if (nco_we_i) begin
            wr_ptr   <= {{(ADDR_W-1){1'b0}}, 1'b1};
            loaded_o <= 1'b0;
            state    <= S_LOAD;
          end else if (en_i && loaded_o) begin
            phase_q <= {PHASE_W{1'b0}};
            step_q  <= nco_freq_step_i;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          wrap_o <= 1'b0;
          if (nco_we_i) begin
            if (wr_ptr == {ADDR_W{1'b1}}) begin
              wr_ptr   <= {ADDR_W{1'b0}};
              loaded_o <= 1'b1;
              state    <= S_IDLE;
            end else begin
              wr_ptr <= wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state <= S_LOAD;
          end
        end
        S_RUN: begin
          if (nco_we_i) begin
            wr_drop_o <= 1'b1;
          end else begin
            wr_drop_o <= wr_drop_o;
          end
          if (!en_i) begin
            phase_q <= {PHASE_W{1'b0}};
            wrap_o  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            phase_q <= phase_sum[PHASE_W-1:0];
            wrap_o  <= phase_sum[PHASE_W];
            // New step is picked up only on the carry, keeping each period whole.
            if (phase_sum[PHASE_W]) begin
              step_q <= nco_freq_step_i;
            end else begin
              step_q <= step_q;
            end
          end
        end
        default: begin
          wrap_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_core.sv
// Self-checking bench for nco_core: constant vector table, directed multi-cycle scenarios
// and randomized traffic, all compared against an integer-arithmetic reference model.
module tb_nco_core;

  logic        clk = 1'b0;
  logic        reset_n, en_i, nco_we_i;
  logic [7:0]  nco_data_i;
  logic [13:0] nco_freq_step_i;
  logic [7:0]  sample_o;
  logic        sample_vld_o, wrap_o, loaded_o, wr_drop_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nco_core dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (en_i),
    .nco_we_i       (nco_we_i),
    .nco_data_i     (nco_data_i),
    .nco_freq_step_i(nco_freq_step_i),
    .sample_o       (sample_o),
    .sample_vld_o   (sample_vld_o),
    .wrap_o         (wrap_o),
    .loaded_o       (loaded_o),
    .wr_drop_o      (wr_drop_o)
  );

  // Reference model: table contents, write count, phase as plain integers.
  bit [7:0]    m_tab [256];
  bit          m_run, m_loading, m_loaded, m_drop, m_vld, m_wrap;
  bit [7:0]    m_sample;
  int unsigned m_phase, m_step, m_cnt;

  task automatic model_step(input bit r, input bit e, input bit w,
                            input bit [7:0] d, input bit [13:0] f);
    int unsigned s;
    if (!r) begin
      m_run = 0; m_loading = 0; m_loaded = 0; m_drop = 0; m_vld = 0; m_wrap = 0;
      m_sample = 8'd0; m_phase = 0; m_step = 0; m_cnt = 0;
    end else if (m_run) begin
      m_vld = 1;
      m_sample = m_tab[m_phase / 4096];
      if (w) m_drop = 1;
      if (!e) begin
        m_run = 0; m_phase = 0; m_wrap = 0;
      end else begin
        s = m_phase + m_step;
        m_wrap = (s >= 1048576);
        m_phase = s % 1048576;
        if (m_wrap) m_step = f;
      end
    end else begin
      m_vld = 0; m_wrap = 0;
      if (w) begin
        if (!m_loading) begin
          m_cnt = 0; m_loaded = 0; m_loading = 1;
        end
        m_tab[m_cnt] = d;
        m_cnt = m_cnt + 1;
        if (m_cnt == 256) begin
          m_loading = 0; m_loaded = 1; m_cnt = 0;
        end
      end else if (e && m_loaded && !m_loading) begin
        m_run = 1; m_phase = 0; m_step = f;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive, advance model, sample #1 after the edge, compare all outputs.
  task automatic tick(input bit r, input bit e, input bit w,
                      input bit [7:0] d, input bit [13:0] f);
    reset_n = r; en_i = e; nco_we_i = w; nco_data_i = d; nco_freq_step_i = f;
    @(posedge clk);
    model_step(r, e, w, d, f);
    #1;
    cmp("model", 32'({sample_o, sample_vld_o, wrap_o, loaded_o, wr_drop_o}),
        32'({m_sample, m_vld, m_wrap, m_loaded, m_drop}));
  endtask

  task automatic load_ramp(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 1, 8'(i), 14'd0);
  endtask

  typedef struct {
    bit r, e, w;
    bit [7:0] d;
    bit [13:0] f;
    bit [7:0] s;
    bit v, wr, ld, dr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit [13:0] rf;
    bit        re;
    tbl[0] = '{r:0, e:0, w:0, d:8'h00, f:14'd0,    s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[1] = '{r:1, e:1, w:0, d:8'h00, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[2] = '{r:1, e:0, w:1, d:8'hAA, f:14'd0,    s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[3] = '{r:1, e:1, w:1, d:8'h55, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[4] = '{r:1, e:1, w:0, d:8'h00, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[5] = '{r:0, e:1, w:0, d:8'h00, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[6] = '{r:1, e:1, w:0, d:8'h00, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    tbl[7] = '{r:1, e:1, w:0, d:8'h00, f:14'd4096, s:8'h00, v:0, wr:0, ld:0, dr:0};
    reset_n = 0; en_i = 0; nco_we_i = 0; nco_data_i = 8'd0; nco_freq_step_i = 14'd0;
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].d, tbl[i].f);
      cmp("tbl_vec", 32'({sample_o, sample_vld_o, wrap_o, loaded_o, wr_drop_o}),
          32'({tbl[i].s, tbl[i].v, tbl[i].wr, tbl[i].ld, tbl[i].dr}));
    end

    // Ramp load and run at one address per cycle.
    load_ramp(255);
    cmp("loaded_before_last", 32'(loaded_o), 32'd0);
    tick(1, 0, 1, 8'd255, 14'd0);
    cmp("loaded_after_256", 32'(loaded_o), 32'd1);
    tick(1, 1, 0, 8'd0, 14'd4096);
    cmp("vld_entry", 32'(sample_vld_o), 32'd0);
    for (int k = 1; k <= 600; k++) begin
      tick(1, 1, 0, 8'd0, 14'd4096);
      cmp("ramp_sample", 32'(sample_o), 32'((k - 1) % 256));
      cmp("ramp_wrap", 32'(wrap_o), 32'((k % 256) == 0));
    end
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 0, 0, 8'd0, 14'd0);

    // Slow step: four cycles per table entry.
    tick(1, 1, 0, 8'd0, 14'd1024);
    for (int k = 1; k <= 2100; k++) begin
      tick(1, 1, 0, 8'd0, 14'd1024);
      if (k % 50 == 1) cmp("slow_sample", 32'(sample_o), 32'(((k - 1) / 4) % 256));
      cmp("slow_wrap", 32'(wrap_o), 32'((k % 1024) == 0));
    end
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 0, 0, 8'd0, 14'd0);

    // Step change mid-period only lands at the wrap.
    tick(1, 1, 0, 8'd0, 14'd4096);
    for (int k = 1; k <= 300; k++) begin
      tick(1, 1, 0, 8'd0, (k > 100) ? 14'd8192 : 14'd4096);
      cmp("chg_sample", 32'(sample_o), (k <= 256) ? 32'(k - 1) : 32'((2 * (k - 257)) % 256));
      cmp("chg_wrap", 32'(wrap_o), 32'(k == 256));
    end
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 0, 0, 8'd0, 14'd0);

    // Write during run is dropped and flagged stickily.
    tick(1, 1, 0, 8'd0, 14'd4096);
    for (int k = 1; k <= 40; k++) begin
      tick(1, 1, (k == 10), 8'hFF, 14'd4096);
      if (k >= 10) cmp("drop_sticky", 32'(wr_drop_o), 32'd1);
    end
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 1, 0, 8'd0, 14'd4096);
    for (int k = 1; k <= 300; k++) begin
      tick(1, 1, 0, 8'd0, 14'd4096);
      cmp("rerun_sample", 32'(sample_o), 32'((k - 1) % 256));
    end
    cmp("drop_still", 32'(wr_drop_o), 32'd1);
    tick(1, 0, 0, 8'd0, 14'd0);

    // Reset mid-load blocks running until a full reload.
    tick(0, 0, 0, 8'd0, 14'd0);
    load_ramp(100);
    tick(0, 0, 0, 8'd0, 14'd0);
    for (int k = 0; k < 20; k++) begin
      tick(1, 1, 0, 8'd0, 14'd4096);
      cmp("rml_vld", 32'(sample_vld_o), 32'd0);
      cmp("rml_loaded", 32'(loaded_o), 32'd0);
    end
    load_ramp(256);
    cmp("rml_reloaded", 32'(loaded_o), 32'd1);
    tick(1, 1, 0, 8'd0, 14'd4096);
    for (int k = 1; k <= 300; k++) begin
      tick(1, 1, 0, 8'd0, 14'd4096);
      cmp("rml_sample", 32'(sample_o), 32'((k - 1) % 256));
    end

    // Stop at sample 50, then restart from table[0].
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 0, 0, 8'd0, 14'd0);
    tick(1, 1, 0, 8'd0, 14'd4096);
    for (int k = 1; k <= 50; k++) tick(1, 1, 0, 8'd0, 14'd4096);
    cmp("stop_s49", 32'(sample_o), 32'd49);
    tick(1, 0, 0, 8'd0, 14'd4096);
    cmp("stop_last_vld", 32'(sample_vld_o), 32'd1);
    cmp("stop_last_s", 32'(sample_o), 32'd50);
    tick(1, 0, 0, 8'd0, 14'd4096);
    cmp("stop_vld", 32'(sample_vld_o), 32'd0);
    cmp("stop_hold", 32'(sample_o), 32'd50);
    tick(1, 1, 0, 8'd0, 14'd4096);
    tick(1, 1, 0, 8'd0, 14'd4096);
    cmp("restart_vld", 32'(sample_vld_o), 32'd1);
    cmp("restart_s0", 32'(sample_o), 32'd0);

    // Randomized traffic against the model, including zero step and rare resets.
    rf = 14'd4096;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 49) == 0)
        rf = ($urandom_range(0, 3) == 0) ? 14'd0 : 14'($urandom_range(0, 16383));
      re = ($urandom_range(0, 29) != 0);
      tick(($urandom_range(0, 1499) != 0), re, ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
